// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA pixel timing: line/frame counters, sync/blank decode, GBA-window coordinates, frame tick/count.
// Define VGA_PREFETCH_EN to register hs/vs/blank/frame_clk one clock behind DrawX/DrawY.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int WIN_X0    = 80,
  parameter int WIN_Y0    = 80,
  parameter int WIN_W     = 480,
  parameter int WIN_H     = 320
) (
  input  logic        vga_clk,
  input  logic        Reset,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        win_on,
  output logic [8:0]  WinX,
  output logic [8:0]  WinY,
  output logic        frame_clk,
  output logic        frame_tick,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_STOP  = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_STOP  = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] WX_START = 10'(WIN_X0);
  localparam logic [9:0] WX_STOP  = 10'(WIN_X0 + WIN_W);
  localparam logic [9:0] WY_START = 10'(WIN_Y0);
  localparam logic [9:0] WY_STOP  = 10'(WIN_Y0 + WIN_H);

  logic [9:0]  hc;
  logic [9:0]  vc;
  logic [15:0] frame_cnt_q;
  logic        h_end;
  logic        v_end;
  logic        hs_d;
  logic        vs_d;
  logic        blank_d;
  logic        tick_d;

  assign h_end = (hc == H_LAST);
  assign v_end = (vc == V_LAST);

  // vc only advances on the last clock of a line, so (last,last) wraps to (0,0) in one edge
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      hc <= '0;
      vc <= '0;
    end else begin
      if (h_end) begin
        hc <= '0;
        if (v_end) vc <= '0;
        else       vc <= vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

  assign hs_d    = !((hc >= HS_START) && (hc < HS_STOP));
  assign vs_d    = !((vc >= VS_START) && (vc < VS_STOP));
  assign blank_d = (hc < H_VIS) && (vc < V_VIS);

  assign win_on = (hc >= WX_START) && (hc < WX_STOP) &&
                  (vc >= WY_START) && (vc < WY_STOP);
  assign WinX   = win_on ? 9'(hc - WX_START) : '0;
  assign WinY   = win_on ? 9'(vc - WY_START) : '0;

  // First blanking clock of the frame: start of the first line below the visible area
  assign tick_d     = (hc == '0) && (vc == V_VIS);
  assign frame_tick = tick_d;

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      frame_cnt_q <= '0;
    end else if (tick_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_count = frame_cnt_q;

`ifdef VGA_PREFETCH_EN
  logic hs_q;
  logic vs_q;
  logic blank_q;
  logic frame_clk_q;

  // Sync/blank lag DrawX by one clock to line up with a registered RGB lookup downstream
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_q     <= 1'b0;
      frame_clk_q <= 1'b1;
    end else begin
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      blank_q     <= blank_d;
      frame_clk_q <= vs_d;
    end
  end

  assign hs        = hs_q;
  assign vs        = vs_q;
  assign blank     = blank_q;
  assign frame_clk = frame_clk_q;
`else
  assign hs        = hs_d;
  assign vs        = vs_d;
  assign blank     = blank_d;
  assign frame_clk = vs_d;
`endif

endmodule
